// File: rtl/uart_tx_if.sv
// Word-request handshake and serial-line signals of the UART transmitter.
// The control side uses the master modport; uart_tx uses the slave modport.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       tx_start;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [2:0] curr_state;

  modport master (
    output data_in, tx_start,
    input  tx, busy, tx_done, curr_state
  );

  modport slave (
    input  data_in, tx_start,
    output tx, busy, tx_done, curr_state
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, parity bit, STOP_BITS stop bits.
// Every output comes straight from a flop, so tx cannot glitch between bits.
module uart_tx #(
  parameter int BAUD_RATE = 4,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic       clk,
  input logic       reset,
  uart_tx_if.slave  bus
);

  localparam int CW = $clog2(2 * STOP_BITS * BAUD_RATE + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(2 * BAUD_RATE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * 2 * BAUD_RATE - 1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_PAR   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  function automatic logic parity_of(input logic [7:0] d);
    if (PARITY == 0) return ^d;
    else             return ~^d;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          tx_done_q, tx_done_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  // Next-state, next-output computation; tx_d is the level shown after the coming edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    bit_end   = (cnt_q == BIT_LAST);
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
      ST_IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_start) begin
          shift_d   = bus.data_in;
          par_d     = parity_of(bus.data_in);
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = ST_START;
          tx_d      = 1'b0;
        end else begin
          cnt_d = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_PAR;
            tx_d    = par_q;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        // Stop phase spans all stop bits with one counter run, hence the wider counter.
        if (cnt_q == STOP_LAST) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
          tx_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = ST_INIT;
        cnt_d     = '0;
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.busy       = busy_q;
  assign bus.curr_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (even/1 stop, odd/1 stop, even/2 stop) checked
// against a frame-level reference model and a behavioural serial receiver.
module tb_uart_tx;

  localparam int BAUD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       start_v [3];
  logic [7:0] data_v  [3];
  logic       tx_w    [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic [2:0] state_w [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();

  uart_tx #(.BAUD_RATE(BAUD), .PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .reset(rst_n), .bus(if0.slave));
  uart_tx #(.BAUD_RATE(BAUD), .PARITY(1), .STOP_BITS(1)) dut1 (.clk(clk), .reset(rst_n), .bus(if1.slave));
  uart_tx #(.BAUD_RATE(BAUD), .PARITY(0), .STOP_BITS(2)) dut2 (.clk(clk), .reset(rst_n), .bus(if2.slave));

  assign if0.tx_start = start_v[0]; assign if0.data_in = data_v[0];
  assign if1.tx_start = start_v[1]; assign if1.data_in = data_v[1];
  assign if2.tx_start = start_v[2]; assign if2.data_in = data_v[2];
  assign tx_w[0] = if0.tx; assign busy_w[0] = if0.busy; assign done_w[0] = if0.tx_done; assign state_w[0] = if0.curr_state;
  assign tx_w[1] = if1.tx; assign busy_w[1] = if1.busy; assign done_w[1] = if1.tx_done; assign state_w[1] = if1.curr_state;
  assign tx_w[2] = if2.tx; assign busy_w[2] = if2.busy; assign done_w[2] = if2.tx_done; assign state_w[2] = if2.curr_state;

  function automatic int par_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int stop_of(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int d);
    return (10 + stop_of(d)) * 2 * BAUD;
  endfunction

  // Parity chosen so that data+parity has an even (PARITY=0) or odd (PARITY=1) number of ones.
  function automatic logic exp_parity(input int d, input logic [7:0] data);
    int ones = 0;
    for (int b = 0; b < 8; b++) ones += int'(data[b]);
    if (par_of(d) == 0) return (ones % 2) == 1;
    else                return (ones % 2) == 0;
  endfunction

  // Expected line level t clocks after the accept edge: slot 0 start, 1..8 data, 9 parity, then stop.
  function automatic logic exp_level(input int d, input logic [7:0] data, input int t);
    int slot = t / (2 * BAUD);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return data[slot-1];
    if (slot == 9) return exp_parity(d, data);
    return 1'b1;
  endfunction

  task automatic send_frame(input int d, input logic [7:0] data, input string name,
                            input int inject_at, output logic par_obs);
    int len, bad, first_t;
    logic first_obs, first_exp, e;
    len = frame_len(d);
    bad = 0; first_t = 0; first_obs = 1'b0; first_exp = 1'b0; par_obs = 1'b0;
    @(negedge clk);
    data_v[d] = data; start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0; data_v[d] = ~data;
    for (int t = 0; t < len; t++) begin
      if (t > 0) @(negedge clk);
      e = exp_level(d, data, t);
      if (t == 9 * 2 * BAUD + BAUD) par_obs = tx_w[d];
      if (tx_w[d] !== e || done_w[d] !== 1'b0 || busy_w[d] !== 1'b1) begin
        if (bad == 0) begin first_t = t; first_obs = tx_w[d]; first_exp = e; end
        bad++;
      end
      if (t == inject_at) begin data_v[d] = 8'h3C; start_v[d] = 1'b1; end
      else if (t == inject_at + 1) start_v[d] = 1'b0;
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL %s frame: %0d bad clocks, first at clock %0d tx=%b expected %b (busy/done also checked)",
               name, bad, first_t, first_obs, first_exp);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || tx_w[d] !== 1'b1)
      $display("FAIL %s done: tx_done=%b busy=%b tx=%b at clock %0d, expected 1 0 1", name, done_w[d], busy_w[d], tx_w[d], len);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done_w[d] !== 1'b0 || tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0)
      $display("FAIL %s after-done: tx_done=%b tx=%b busy=%b, expected 0 1 0", name, done_w[d], tx_w[d], busy_w[d]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (tx_w[d] !== 1'b1 || busy_w[d] !== 1'b1 || done_w[d] !== 1'b0 || state_w[d] !== 3'd0)
        $display("FAIL reset dut%0d: tx=%b busy=%b done=%b state=%0d, expected 1 1 0 0", d, tx_w[d], busy_w[d], done_w[d], state_w[d]);
      else n_pass++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (tx_w[d] !== 1'b1 || busy_w[d] !== 1'b0 || state_w[d] !== 3'd1)
        $display("FAIL idle dut%0d: tx=%b busy=%b state=%0d, expected 1 0 1", d, tx_w[d], busy_w[d], state_w[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_vs_start();
    @(negedge clk);
    rst_n = 1'b0; start_v[0] = 1'b1; data_v[0] = 8'h00;
    @(negedge clk);
    n_checks++;
    if (state_w[0] !== 3'd0 || tx_w[0] !== 1'b1)
      $display("FAIL reset_vs_start: state=%0d tx=%b, expected 0 1", state_w[0], tx_w[0]);
    else n_pass++;
    rst_n = 1'b1; start_v[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_w[0] !== 3'd1 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0)
      $display("FAIL reset_vs_start idle: state=%0d tx=%b busy=%b, expected 1 1 0", state_w[0], tx_w[0], busy_w[0]);
    else n_pass++;
  endtask

  task automatic test_patterns();
    logic p;
    send_frame(0, 8'hA5, "a5_even", -1, p);
    n_checks++;
    if (p !== 1'b0) $display("FAIL parity a5_even: got %b, expected 0", p); else n_pass++;
    send_frame(0, 8'h07, "07_even", -1, p);
    n_checks++;
    if (p !== 1'b1) $display("FAIL parity 07_even: got %b, expected 1", p); else n_pass++;
    send_frame(1, 8'h07, "07_odd", -1, p);
    n_checks++;
    if (p !== 1'b0) $display("FAIL parity 07_odd: got %b, expected 0", p); else n_pass++;
    send_frame(1, 8'h00, "00_odd", -1, p);
    n_checks++;
    if (p !== 1'b1) $display("FAIL parity 00_odd: got %b, expected 1", p); else n_pass++;
  endtask

  task automatic test_random();
    logic p;
    for (int i = 0; i < 6; i++) begin
      send_frame(int'($urandom_range(0, 2)), 8'($urandom), $sformatf("rand%0d", i), -1, p);
    end
  endtask

  task automatic test_ignored_request();
    logic p;
    int bad = 0;
    send_frame(0, 8'h5A, "ignored_5a", 20, p);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ignored_request: %0d non-idle clocks after frame, expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic samp[$];
    int len, dones, i, s, n_rx;
    int starts[$];
    logic [7:0] words[$];
    int perr;
    logic [7:0] w;
    logic pb;
    len = frame_len(0);
    dones = 0;
    @(negedge clk);
    data_v[0] = 8'h11; start_v[0] = 1'b1;
    for (int k = 0; k < 2 * len + 12; k++) begin
      @(negedge clk);
      samp.push_back(tx_w[0]);
      if (done_w[0] === 1'b1) begin
        dones++;
        if (dones == 1) data_v[0] = 8'hEE;
        else start_v[0] = 1'b0;
      end
    end
    start_v[0] = 1'b0;
    // Behavioural receiver: detect start, sample each bit mid-period.
    i = 0; perr = 0;
    while (i < samp.size()) begin
      if (samp[i] == 1'b0 && i + 10 * 2 * BAUD + BAUD < samp.size()) begin
        s = i;
        for (int b = 0; b < 8; b++) w[b] = samp[s + (1 + b) * 2 * BAUD + BAUD];
        pb = samp[s + 9 * 2 * BAUD + BAUD];
        if ((^w) != pb || samp[s + 10 * 2 * BAUD + BAUD] != 1'b1) perr++;
        words.push_back(w);
        starts.push_back(s);
        i = s + len;
      end else begin
        i++;
      end
    end
    n_rx = words.size();
    n_checks++;
    if (n_rx != 2 || dones != 2) $display("FAIL b2b count: %0d words, %0d tx_done, expected 2 2", n_rx, dones);
    else n_pass++;
    if (n_rx == 2) begin
      n_checks++;
      if (words[0] !== 8'h11 || words[1] !== 8'hEE)
        $display("FAIL b2b data: got %h %h, expected 11 ee", words[0], words[1]);
      else n_pass++;
      n_checks++;
      if (starts[1] - starts[0] != len + 1)
        $display("FAIL b2b gap: start spacing %0d, expected %0d", starts[1] - starts[0], len + 1);
      else n_pass++;
    end
    n_checks++;
    if (perr != 0) $display("FAIL b2b parity_error: %0d frames, expected 0", perr);
    else n_pass++;
  endtask

  task automatic test_abort_stop2();
    logic p;
    int bad;
    @(negedge clk);
    data_v[2] = 8'h96; start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    for (int t = 1; t <= 4 * 2 * BAUD + 3; t++) @(negedge clk);
    n_checks++;
    if (tx_w[2] !== 1'b0 || state_w[2] !== 3'd3)
      $display("FAIL abort pre: tx=%b state=%0d in data bit 3, expected 0 3", tx_w[2], state_w[2]);
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_w[2] !== 1'b1 || done_w[2] !== 1'b0 || state_w[2] !== 3'd0 || busy_w[2] !== 1'b1)
      $display("FAIL abort edge: tx=%b done=%b state=%0d busy=%b, expected 1 0 0 1", tx_w[2], done_w[2], state_w[2], busy_w[2]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_w[2] !== 1'b0 || tx_w[2] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL abort no_done: %0d clocks with tx_done or low tx, expected 0", bad);
    else n_pass++;
    send_frame(2, 8'h96, "stop2_96", -1, p);
    send_frame(2, 8'h3B, "stop2_3b", -1, p);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin start_v[d] = 1'b0; data_v[d] = 8'h00; end
    test_reset();
    test_reset_vs_start();
    test_patterns();
    test_ignored_request();
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_abort_stop2();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
